// File: rtl/otter_intr_pkg.sv
// ---------------------------------------------------------------------------
// otter_intr_pkg
// Shared types and helpers for the OTTER interrupt controller.
//   intr_state_t   : controller states (IDLE, REQ, SERVICE)
//   DEF_N_SRC      : default number of interrupt sources
//   DEF_SYNC_STAGES: default synchronizer depth per source
//   lowestSetBit() : fixed priority select, bit 0 is the highest priority
// ---------------------------------------------------------------------------
package otter_intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intr_state_t;

    localparam int DEF_N_SRC       = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // Returns the index of the lowest set bit of a 16-bit vector (0 when the
    // vector is empty; callers qualify the result with their own any-set test).
    // Scanning from the top down lets the lowest index overwrite the result last.
    function automatic logic [3:0] lowestSetBit(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// ---------------------------------------------------------------------------
// intr_sync_edge
// Brings one asynchronous interrupt line into the clk domain and emits a
// single-cycle pulse for every rising edge seen on the synchronized level.
// Ports:
//   clk    : system clock
//   RST    : synchronous active-high reset
//   src_i  : raw asynchronous source line
//   edge_o : one-cycle pulse, high for one clock per synchronized rising edge
// ---------------------------------------------------------------------------
module intr_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic RST,
    input  logic src_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic [SYNC_STAGES:0]   ready_q;

    // Metastability chain: the raw line shifts in at bit 0 and the settled
    // level appears at the top bit. The delay flop keeps the previous settled
    // level so a rising edge can be recognised.
    always_ff @(posedge clk) begin
        if (RST) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    // After reset the chain holds zeros that were never sampled from the line.
    // This shift register fills with ones in step with the chain, so edge
    // detection only starts once both the settled level and its delayed copy
    // come from real samples. Without it a line held high through reset would
    // look like a fresh rising edge on release.
    always_ff @(posedge clk) begin
        if (RST) begin
            ready_q <= '0;
        end else begin
            ready_q <= {ready_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // A level held high produces exactly one pulse: after the first cycle the
    // delayed copy catches up and the pulse clears.
    always_comb begin
        edge_o = sync_q[SYNC_STAGES-1] & ~dly_q & ready_q[SYNC_STAGES];
    end

endmodule

// File: rtl/otter_intr_ctrl.sv
// ---------------------------------------------------------------------------
// otter_intr_ctrl
// Interrupt controller for the OTTER multicycle control FSM. Latches rising
// edges of N_SRC asynchronous sources as pending bits, masks them with the
// per-source and global enables, requests the highest-priority one and
// captures its index when the control FSM takes the interrupt. Further
// requests are held off until the handler returns with mret.
// Ports:
//   clk        : system clock, all logic on posedge
//   RST        : synchronous active-high reset
//   irq_src    : raw asynchronous source lines (rising-edge events)
//   irq_en     : per-source enables (mie CSR field)
//   mie        : global enable (mstatus.MIE)
//   int_taken  : one-cycle pulse from the control FSM's interrupt state
//   mret       : one-cycle pulse when the handler return executes
//   intr       : level interrupt request to the control FSM
//   int_cause  : index of the source that was taken
//   pending    : pending-event register, readable via CSR
//   in_service : handler active
// ---------------------------------------------------------------------------
module otter_intr_ctrl
    import otter_intr_pkg::*;
#(
    parameter  int N_SRC       = DEF_N_SRC,
    parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int CAUSE_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [N_SRC-1:0]   irq_src,
    input  logic [N_SRC-1:0]   irq_en,
    input  logic               mie,
    input  logic               int_taken,
    input  logic               mret,
    output logic               intr,
    output logic [CAUSE_W-1:0] int_cause,
    output logic [N_SRC-1:0]   pending,
    output logic               in_service
);

    intr_state_t        state_q, state_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;

    logic [N_SRC-1:0]   srcEdge;
    logic [N_SRC-1:0]   elig;
    logic [15:0]        eligWide;
    logic [3:0]         sel;
    logic               anyElig;
    logic               take;
    logic [N_SRC-1:0]   clrMask;

    // One synchronizer / edge detector per source line.
    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        intr_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk    (clk),
            .RST    (RST),
            .src_i  (irq_src[g]),
            .edge_o (srcEdge[g])
        );
    end

    // Eligibility and priority: only enabled pending events compete, and the
    // lowest index wins. The vector is widened to the helper's fixed width.
    always_comb begin
        elig     = pending_q & irq_en;
        eligWide = '0;
        eligWide[N_SRC-1:0] = elig;
        sel      = lowestSetBit(eligWide);
        anyElig  = |elig;
    end

    // Next-state logic. An int_taken in REQ is accepted only when something is
    // still eligible; that acceptance beats a simultaneous withdraw (mie low).
    // Stray int_taken outside REQ and stray mret outside SERVICE fall through
    // to the hold defaults.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mie && anyElig) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (int_taken && anyElig) begin
                    take    = 1'b1;
                    state_d = SERVICE;
                end else if (!mie || !anyElig) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (mret) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending and cause update. The taken source is cleared, but a new edge on
    // that same source in the same cycle sets it again, so set wins. Events are
    // latched regardless of enables so masked interrupts are not lost.
    always_comb begin
        clrMask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clrMask[i] = take && (sel == 4'(i));
        end
        pending_d = (pending_q & ~clrMask) | srcEdge;
        cause_d   = take ? sel[CAUSE_W-1:0] : cause_q;
    end

    // State registers. Reset discards every event and drops intr on the same
    // edge, whatever state the controller was in.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= IDLE;
            pending_q <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cause_q   <= cause_d;
        end
    end

    // Outputs are straight decodes of registered state.
    always_comb begin
        intr       = (state_q == REQ);
        in_service = (state_q == SERVICE);
        pending    = pending_q;
        int_cause  = cause_q;
    end

endmodule
